spwm_lut_sched: RTL
===================

SPWM_LUT_SCHED -- requirements
Module: spwm_lut_sched

Interface
REQ-001 Parameter SIZE, default 407: sine LUT depth in samples; one period of the waveform.
REQ-002 Parameter PRESC, default 100: clk_in cycles per sample tick; legal range 6..65535.
REQ-003 Parameter OFF_B, default 135 (SIZE/3): phase-B index offset.
REQ-004 Parameter OFF_C, default 271 (2*SIZE/3): phase-C index offset.
REQ-005 Port clk_in, input, 1: single clock; all logic on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port en, input, 1: run enable for the prescaler and sequencer.
REQ-008 Port step, input, 9: LUT index increment applied per tick (frequency word).
REQ-009 Port lut_addr, output, 9: read address to the shared 12-bit sine LUT.
REQ-010 Port lut_rd, output, 1: read strobe; LUT returns lut_data exactly 1 cycle later.
REQ-011 Port lut_data, input, 12: LUT read data.
REQ-012 Port samp_a / samp_b / samp_c, output, 12 each: registered phase samples.
REQ-013 Port samp_valid, output, 1: one-cycle pulse when all three samples have updated together.
REQ-014 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-015 Port err, output, 1: sticky flag for an illegal step value.

Function
REQ-016 Prescaler: counts 0..PRESC-1 while en=1; tick asserts in the cycle the count equals PRESC-1; the count then wraps to 0.
REQ-017 With en=0 and the FSM in IDLE, the prescaler clears to 0 and holds.
REQ-018 FSM states: IDLE, RD_A, RD_B, RD_C, CAP, UPD; each non-IDLE state lasts exactly 1 cycle.
REQ-019 IDLE->RD_A on tick; RD_A->RD_B->RD_C->CAP->UPD->IDLE unconditionally.
REQ-020 Clearing en mid-sequence does not abort it; the sequence completes, then the FSM holds in IDLE.
REQ-021 Tick at cycle T: lut_rd=1 in T+1..T+3 with lut_addr = idx_a, idx_b, idx_c respectively; lut_rd=0 in all other cycles.
REQ-022 idx_a = base; idx_b = (base+OFF_B) mod SIZE; idx_c = (base+OFF_C) mod SIZE; each is computed by compare-and-subtract, with no divider.
REQ-023 lut_data is captured into hold A at T+2, hold B at T+3 and hold C at T+4.
REQ-024 samp_a, samp_b and samp_c load from the hold registers simultaneously at T+5; samp_valid=1 in T+5 only.
REQ-025 At the T+5 edge, base <= (base+step) mod SIZE when step < SIZE; the sum never exceeds 2*SIZE-2.
REQ-026 If step >= SIZE at UPD: base holds, err is set, and samples still update.
REQ-027 err clears only on rst.
REQ-028 A step change takes effect at the next UPD only; step is sampled in UPD.
REQ-029 Tick-to-samp_valid latency is 5 cycles; busy=1 in T+1..T+5.

Reset
REQ-030 rst=1 forces, at the next edge: FSM=IDLE, prescaler=0, base=0, hold A/B/C=0.
REQ-031 rst=1 also forces: samp_a/b/c=0, samp_valid=0, lut_rd=0, lut_addr=0, busy=0, err=0.
REQ-032 rst overrides any in-flight sequence; no partial sample update is ever emitted afterwards.

Configuration
REQ-033 Macro SPWM_SCHED_FRAMECNT_EN defined: adds output frame_cnt, 16 bits, reset 0.
REQ-034 With the macro, frame_cnt increments by 1 at each UPD where base+step >= SIZE (index wrap); it wraps modulo 2^16.
REQ-035 Without the macro, the frame_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-036 PRESC=8, step=1, en=1 after reset -> tick at cycle 7; lut_addr=0,135,271 in cycles 8-10; samp_valid in cycle 12 with samp_a=LUT[0], samp_b=LUT[135], samp_c=LUT[271].
REQ-037 base=406, step=1 -> next idx_a=0, idx_b=135, idx_c=271; with the macro, frame_cnt 0->1.
REQ-038 base=300, step=200 -> next base=93, idx_b=228, idx_c=364.
REQ-039 step=407 at UPD -> err=1, base unchanged, samp_valid still pulses; err persists until rst.
REQ-040 en dropped in RD_B -> sequence completes with samp_valid at T+5; no further tick; prescaler reads 0.
REQ-041 rst asserted in RD_C -> all outputs 0 the next cycle; no samp_valid; the first post-reset sequence reads address 0.

Source files
------------

// File: rtl/spwm_lut_sched.sv
// Three-phase SPWM sample scheduler: one shared sine LUT is read for phases A/B/C per tick.
// Optional SPWM_SCHED_FRAMECNT_EN adds a 16-bit frame_cnt output counting index wraps.
module spwm_lut_sched #(
    parameter int SIZE  = 407,
    parameter int PRESC = 100,
    parameter int OFF_B = 135,
    parameter int OFF_C = 271
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        en,
    input  logic [8:0]  step,
    output logic [8:0]  lut_addr,
    output logic        lut_rd,
    input  logic [11:0] lut_data,
    output logic [11:0] samp_a,
    output logic [11:0] samp_b,
    output logic [11:0] samp_c,
    output logic        samp_valid,
    output logic        busy,
    output logic        err
`ifdef SPWM_SCHED_FRAMECNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, CAP, UPD} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [8:0]  base;
    logic [11:0] hold_a, hold_b;
    logic        tick, step_ok, wrap;
    logic [9:0]  sum_b, sum_c, sum_step;
    logic [8:0]  idx_b, idx_c, base_next;

    always_comb begin
        tick      = en && (cnt == 16'(PRESC - 1));
        sum_b     = {1'b0, base} + 10'(OFF_B);
        sum_c     = {1'b0, base} + 10'(OFF_C);
        sum_step  = {1'b0, base} + {1'b0, step};
        idx_b     = (sum_b >= 10'(SIZE)) ? 9'(sum_b - 10'(SIZE)) : sum_b[8:0];
        idx_c     = (sum_c >= 10'(SIZE)) ? 9'(sum_c - 10'(SIZE)) : sum_c[8:0];
        step_ok   = ({1'b0, step} < 10'(SIZE));
        wrap      = (sum_step >= 10'(SIZE));
        base_next = wrap ? 9'(sum_step - 10'(SIZE)) : sum_step[8:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 16'd1;
        end else if (state == IDLE) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            hold_a     <= '0;
            hold_b     <= '0;
            lut_addr   <= '0;
            lut_rd     <= 1'b0;
            samp_a     <= '0;
            samp_b     <= '0;
            samp_c     <= '0;
            samp_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
`ifdef SPWM_SCHED_FRAMECNT_EN
            frame_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (tick) begin
                    state    <= RD_A;
                    lut_rd   <= 1'b1;
                    lut_addr <= base;
                    busy     <= 1'b1;
                end
                RD_A: begin
                    state    <= RD_B;
                    lut_addr <= idx_b;
                end
                RD_B: begin
                    state    <= RD_C;
                    lut_addr <= idx_c;
                    hold_a   <= lut_data;
                end
                RD_C: begin
                    state  <= CAP;
                    lut_rd <= 1'b0;
                    hold_b <= lut_data;
                end
                CAP: begin
                    // Phase C data arrives this cycle; it goes straight into samp_c so
                    // all three samples become visible together with samp_valid.
                    state      <= UPD;
                    samp_a     <= hold_a;
                    samp_b     <= hold_b;
                    samp_c     <= lut_data;
                    samp_valid <= 1'b1;
                end
                UPD: begin
                    state      <= IDLE;
                    samp_valid <= 1'b0;
                    busy       <= 1'b0;
                    if (step_ok) begin
                        base <= base_next;
`ifdef SPWM_SCHED_FRAMECNT_EN
                        if (wrap) frame_cnt <= frame_cnt + 16'd1;
`endif
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
